// File: rtl/sysctrl_gen.sv
// sysctrl_gen: MCU byte-link system controller with a generic bank of 8-bit config slots.
// Define SYSCTRL_CFG_READBACK_EN to add the CMD 7 config readback path.
module sysctrl_gen #(
    parameter logic [7:0]             CORE_ID       = 8'h00,
    parameter int                     CFG_SLOTS     = 16,
    parameter logic [CFG_SLOTS*8-1:0] CFG_DEFAULTS  = '0,
    parameter int                     INT_W         = 8,
    parameter int unsigned            RESET_TIMEOUT = 86_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in_strobe,
    input  logic                   data_in_start,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    output logic                   int_out_n,
    input  logic [INT_W-1:0]       int_in,
    output logic [INT_W-1:0]       int_ack,
    input  logic [1:0]             buttons,
    output logic [1:0]             leds,
    output logic [23:0]            color,
    output logic                   system_reset,
    output logic [CFG_SLOTS*8-1:0] cfg,
    output logic [CFG_SLOTS-1:0]   cfg_changed
);
    localparam logic [7:0] SLOT_BASE = 8'h41;
    localparam logic [7:0] RESET_ID  = 8'h52;

    typedef enum logic {S_IDLE, S_FRAME} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             byteIdx_q, byteIdx_d;
    logic [7:0]             cmd_q, cmd_d;
    logic [7:0]             id_q, id_d;
    logic [7:0]             dataOut_q, dataOut_d;
    logic                   intOutN_q, intOutN_d;
    logic [INT_W-1:0]       intAck_q, intAck_d;
    logic [1:0]             leds_q, leds_d;
    logic [23:0]            color_q, color_d;
    logic                   sysReset_q, sysReset_d;
    logic                   sysInt_q, sysInt_d;
    logic                   coldboot_q, coldboot_d;
    logic [31:0]            timeout_q, timeout_d;
    logic [CFG_SLOTS*8-1:0] cfg_q, cfg_d;
    logic [CFG_SLOTS-1:0]   cfgChanged_q, cfgChanged_d;

    logic       dataByte;
    logic       cfgWrite;
    logic [7:0] revByte;
    logic [7:0] intStatus;
    logic       unusedIntIn0;

    assign dataByte     = data_in_strobe && !data_in_start && (state_q == S_FRAME);
    assign revByte      = {data_in[0], data_in[1], data_in[2], data_in[3],
                           data_in[4], data_in[5], data_in[6], data_in[7]};
    assign unusedIntIn0 = int_in[0];

    // Bit 0 of the reported interrupt word is the controller's own coldboot interrupt.
    always_comb begin
        intStatus = '0;
        intStatus[INT_W-1:0] = {int_in[INT_W-1:1], sysInt_q};
    end

`ifdef SYSCTRL_CFG_READBACK_EN
    localparam logic [7:0] SLOT_END = 8'(65 + CFG_SLOTS);
    logic [7:0] rdId;
    logic [7:0] rdData;
    logic [7:0] rbTable [32];

    for (genvar g = 0; g < 32; g++) begin : g_rb
        if (g < CFG_SLOTS) begin : g_used
            assign rbTable[g] = cfg_q[8*g +: 8];
        end else begin : g_empty
            assign rbTable[g] = 8'h00;
        end
    end

    assign rdId   = (byteIdx_q == 4'd1) ? data_in : id_q;
    assign rdData = (rdId >= SLOT_BASE && rdId < SLOT_END) ? rbTable[5'(rdId - SLOT_BASE)] : 8'h00;
`endif

    always_comb begin
        state_d    = state_q;
        byteIdx_d  = byteIdx_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        dataOut_d  = dataOut_q;
        intAck_d   = '0;
        leds_d     = leds_q;
        color_d    = color_q;
        sysReset_d = sysReset_q;
        sysInt_d   = sysInt_q;
        coldboot_d = coldboot_q;
        timeout_d  = timeout_q;
        cfgWrite   = 1'b0;

        if (intAck_q[0]) sysInt_d = 1'b0;
        if (timeout_q != 32'd0) timeout_d = timeout_q - 32'd1;
        // Self-release: the core comes out of reset and the LED goes yellow.
        if (timeout_q == 32'd1) begin
            sysReset_d = 1'b0;
            color_d    = 24'h000202;
        end

        if (data_in_strobe && data_in_start) begin
            state_d   = S_FRAME;
            cmd_d     = data_in;
            byteIdx_d = 4'd1;
        end else if (dataByte) begin
            if (byteIdx_q != 4'd15) byteIdx_d = byteIdx_q + 4'd1;
            case (cmd_q)
                8'd0: begin
                    case (byteIdx_q)
                        4'd1:    dataOut_d = 8'h5C;
                        4'd2:    dataOut_d = 8'h42;
                        4'd3:    dataOut_d = CORE_ID;
                        default: ;
                    endcase
                end
                8'd1: if (byteIdx_q == 4'd1) leds_d = data_in[1:0];
                8'd2: begin
                    case (byteIdx_q)
                        4'd1:    color_d[15:8]  = revByte;
                        4'd2:    color_d[7:0]   = revByte;
                        4'd3:    color_d[23:16] = revByte;
                        default: ;
                    endcase
                end
                8'd3: dataOut_d = {6'b0, buttons};
                8'd4: begin
                    if (byteIdx_q == 4'd1) begin
                        id_d = data_in;
                    end else if (byteIdx_q == 4'd2) begin
                        if (id_q == RESET_ID) begin
                            sysReset_d = data_in[0];
                            timeout_d  = 32'd0;
                        end else begin
                            cfgWrite = 1'b1;
                        end
                    end
                end
                8'd5: begin
                    dataOut_d = intStatus;
                    if (byteIdx_q == 4'd1) intAck_d = data_in[INT_W-1:0];
                end
                8'd6: begin
                    dataOut_d = {7'b0, coldboot_q};
                    if (byteIdx_q == 4'd1) coldboot_d = 1'b0;
                end
`ifdef SYSCTRL_CFG_READBACK_EN
                8'd7: begin
                    dataOut_d = rdData;
                    id_d      = rdId + 8'd1;
                end
`endif
                default: ;
            endcase
        end

        intOutN_d = !(sysInt_d || (|int_in[INT_W-1:1]));
    end

    // Slot k answers to id 'A'+k; ids outside the bank never match, so they are ignored.
    for (genvar g = 0; g < CFG_SLOTS; g++) begin : g_slot
        logic hit;
        assign hit = (id_q == 8'(65 + g));
        assign cfg_d[8*g +: 8]  = (cfgWrite && hit) ? data_in : cfg_q[8*g +: 8];
        assign cfgChanged_d[g]  = (cfg_d[8*g +: 8] != cfg_q[8*g +: 8]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byteIdx_q    <= 4'd0;
            cmd_q        <= 8'd0;
            id_q         <= 8'd0;
            dataOut_q    <= 8'd0;
            intOutN_q    <= 1'b0;
            intAck_q     <= '0;
            leds_q       <= 2'b00;
            color_q      <= 24'd0;
            sysReset_q   <= 1'b1;
            sysInt_q     <= 1'b1;
            coldboot_q   <= 1'b1;
            timeout_q    <= 32'(RESET_TIMEOUT);
            cfg_q        <= CFG_DEFAULTS;
            cfgChanged_q <= '0;
        end else begin
            state_q      <= state_d;
            byteIdx_q    <= byteIdx_d;
            cmd_q        <= cmd_d;
            id_q         <= id_d;
            dataOut_q    <= dataOut_d;
            intOutN_q    <= intOutN_d;
            intAck_q     <= intAck_d;
            leds_q       <= leds_d;
            color_q      <= color_d;
            sysReset_q   <= sysReset_d;
            sysInt_q     <= sysInt_d;
            coldboot_q   <= coldboot_d;
            timeout_q    <= timeout_d;
            cfg_q        <= cfg_d;
            cfgChanged_q <= cfgChanged_d;
        end
    end

    assign data_out     = dataOut_q;
    assign int_out_n    = intOutN_q;
    assign int_ack      = intAck_q;
    assign leds         = leds_q;
    assign color        = color_q;
    assign system_reset = sysReset_q;
    assign cfg          = cfg_q;
    assign cfg_changed  = cfgChanged_q;
endmodule
